main_osc_stab_ctl: RTL and testbench
====================================

// Module: main_osc_stab_ctl
// PURPOSE
//  Sequencer for the main oscillator's MSTOP input. Starts and stops the oscillator on CPU request.
//  Counts stabilisation ticks against an OSTS-selected wait and drives OSTC-style status and MAIN_READY.
//  Blocks stopping the oscillator while the CPU runs on the main clock. Sits in csc, between the registers and the oscillator.
// PARAMETERS
//  OSTS_BASE  8   log2 of shortest wait; wait = 2^(OSTS_BASE+OSTS) ticks
//  CNT_W      16  stabilisation counter width; must be >= OSTS_BASE+8
// PORTS
//  BASECK       in   1  sole clock; all logic on rising edge
//  RESET        in   1  synchronous reset, active-high
//  OSCSEL       in   1  1: pins in OSC mode; 0: port mode, forces IDLE
//  START_REQ    in   1  1-cycle pulse: start oscillator
//  STOP_REQ     in   1  1-cycle pulse: stop oscillator
//  OSTS         in   3  wait select, sampled on accepted START_REQ
//  MCLK_TICK    in   1  1-cycle strobe per main-clock period (pre-synchronised)
//  CPU_ON_MAIN  in   1  CPU clock currently sourced from main osc
//  MSTOP        out  1  to oscillator; 1 = stopped
//  MAIN_READY   out  1  stabilisation complete
//  OSTC         out  8  thermometer status; bit i = cnt >= 2^(OSTS_BASE+i)
//  STOP_REJ     out  1  1-cycle pulse: STOP_REQ refused
//  BUSY         out  1  1 while in WAIT
// BEHAVIOUR
//  Outputs: all registered. Reset values: MSTOP=1, MAIN_READY=0, OSTC=0, STOP_REJ=0, BUSY=0.
//   Reset also clears state to IDLE, cnt to 0 and osts_q to 0.
//  States: IDLE, WAIT, READY.
//  IDLE: MSTOP=1, cnt=0, OSTC=0.
//   START_REQ & OSCSEL & ~STOP_REQ -> WAIT on the next edge, with osts_q<=OSTS, MSTOP<=0, BUSY<=1.
//  WAIT: each MCLK_TICK increments cnt by 1; cnt saturates at 2^CNT_W-1.
//   OSTC is updated on the same edge as cnt.
//   When cnt+1 reaches 2^(OSTS_BASE+osts_q) on a tick, go to READY on that edge.
//    MAIN_READY<=1 and BUSY<=0 on that edge, so MAIN_READY has zero added latency after the final tick.
//  READY: cnt keeps counting (saturating) so the upper OSTC bits keep filling. MSTOP=0, MAIN_READY=1.
//  STOP_REQ in WAIT or READY:
//   If CPU_ON_MAIN=1: STOP_REJ=1 for one cycle; state and outputs unchanged.
//   Else: go to IDLE on the next edge; MSTOP<=1, MAIN_READY<=0, OSTC<=0, cnt<=0, BUSY<=0.
//  START_REQ in WAIT or READY: ignored; OSTS is not re-sampled.
//  OSTS changes after the start edge have no effect until the next start.
//  START_REQ and STOP_REQ in the same cycle: STOP wins in every state. In IDLE both are ignored.
//  OSCSEL=0 in any state: IDLE on the next edge, overriding CPU_ON_MAIN; no STOP_REJ pulse.
//   START_REQ is ignored while OSCSEL=0.
//  RESET in any state: takes priority over all inputs; reset values on the next edge.
//   After a STOP or reset, a restart counts from 0.
// TESTING
//  T1 RESET, OSTS=0, START_REQ, MCLK_TICK every cycle:
//     MSTOP=0 one cycle after START_REQ; BUSY=1; MAIN_READY=1 on the edge of tick 256; OSTC=8'h01.
//  T2 OSTS=3, tick every 4th cycle, OSTS changed to 0 mid-wait:
//     READY only at tick 2048; OSTC=8'h0F at READY.
//  T3 In READY with CPU_ON_MAIN=1, STOP_REQ: STOP_REJ high exactly 1 cycle; MSTOP stays 0.
//     Then CPU_ON_MAIN=0, STOP_REQ: next edge MSTOP=1, MAIN_READY=0, OSTC=0.
//  T4 STOP_REQ at tick 100 of WAIT: IDLE, OSTC=0.
//     Then re-START with OSTS=0: READY after 256 new ticks, not 156.
//  T5 OSCSEL dropped in READY with CPU_ON_MAIN=1: IDLE next edge with STOP_REJ=0.
//     START_REQ while OSCSEL=0: no effect. START_REQ and STOP_REQ together in IDLE: stays IDLE.
//  T6 RESET asserted mid-WAIT at tick 50: next edge all outputs at reset values; counter restarts from 0.

Source files
------------

// File: rtl/main_osc_stab_ctl.sv
// Main oscillator MSTOP sequencer: starts/stops the oscillator on request, counts
// stabilisation ticks against the OSTS-selected wait and reports OSTC/MAIN_READY.
module main_osc_stab_ctl #(
    parameter int OSTS_BASE = 8,
    parameter int CNT_W     = 16
) (
    input  logic       BASECK,
    input  logic       RESET,
    input  logic       OSCSEL,
    input  logic       START_REQ,
    input  logic       STOP_REQ,
    input  logic [2:0] OSTS,
    input  logic       MCLK_TICK,
    input  logic       CPU_ON_MAIN,
    output logic       MSTOP,
    output logic       MAIN_READY,
    output logic [7:0] OSTC,
    output logic       STOP_REJ,
    output logic       BUSY
);

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_WAIT  = 2'd1,
        ST_READY = 2'd2
    } state_t;

    state_t           state_q, state_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic [2:0]       osts_q, osts_d;
    logic             mstop_q, mstop_d;
    logic             ready_q, ready_d;
    logic [7:0]       ostc_q, ostc_d;
    logic             rej_q, rej_d;
    logic             busy_q, busy_d;

    logic [CNT_W-1:0] cnt_inc;
    logic [CNT_W-1:0] wait_target;

    assign cnt_inc     = (cnt_q == {CNT_W{1'b1}}) ? cnt_q : cnt_q + CNT_W'(1);
    assign wait_target = CNT_W'(1) << (OSTS_BASE + int'(osts_q));

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        osts_d  = osts_q;
        mstop_d = mstop_q;
        ready_d = ready_q;
        rej_d   = 1'b0;
        busy_d  = busy_q;

        if (!OSCSEL) begin
            // Port mode forces IDLE regardless of CPU clock source
            state_d = ST_IDLE;
            cnt_d   = '0;
            mstop_d = 1'b1;
            ready_d = 1'b0;
            busy_d  = 1'b0;
        end else begin
            case (state_q)
                ST_IDLE: begin
                    if (START_REQ && !STOP_REQ) begin
                        state_d = ST_WAIT;
                        osts_d  = OSTS;
                        cnt_d   = '0;
                        mstop_d = 1'b0;
                        busy_d  = 1'b1;
                    end
                end
                ST_WAIT, ST_READY: begin
                    if (STOP_REQ) begin
                        if (CPU_ON_MAIN) begin
                            rej_d = 1'b1;
                        end else begin
                            state_d = ST_IDLE;
                            cnt_d   = '0;
                            mstop_d = 1'b1;
                            ready_d = 1'b0;
                            busy_d  = 1'b0;
                        end
                    end else if (MCLK_TICK) begin
                        cnt_d = cnt_inc;
                        if (state_q == ST_WAIT && cnt_inc == wait_target) begin
                            state_d = ST_READY;
                            ready_d = 1'b1;
                            busy_d  = 1'b0;
                        end
                    end
                end
                default: begin
                    state_d = ST_IDLE;
                    cnt_d   = '0;
                    mstop_d = 1'b1;
                    ready_d = 1'b0;
                    busy_d  = 1'b0;
                end
            endcase
        end
    end

    // Thermometer status follows the next counter value so it moves on the same edge
    for (genvar gi = 0; gi < 8; gi++) begin : g_ostc
        localparam logic [CNT_W-1:0] TH = CNT_W'(1) << (OSTS_BASE + gi);
        assign ostc_d[gi] = (cnt_d >= TH);
    end

    always_ff @(posedge BASECK) begin
        if (RESET) begin
            state_q <= ST_IDLE;
            cnt_q   <= '0;
            osts_q  <= '0;
            mstop_q <= 1'b1;
            ready_q <= 1'b0;
            ostc_q  <= '0;
            rej_q   <= 1'b0;
            busy_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            osts_q  <= osts_d;
            mstop_q <= mstop_d;
            ready_q <= ready_d;
            ostc_q  <= ostc_d;
            rej_q   <= rej_d;
            busy_q  <= busy_d;
        end
    end

    assign MSTOP      = mstop_q;
    assign MAIN_READY = ready_q;
    assign OSTC       = ostc_q;
    assign STOP_REJ   = rej_q;
    assign BUSY       = busy_q;

endmodule

// File: tb/tb_main_osc_stab_ctl.sv
// Directed bench for main_osc_stab_ctl: linear scenario sequence with immediate assertions.
module tb_main_osc_stab_ctl;

    logic       clk = 1'b0;
    logic       rst;
    logic       oscsel;
    logic       start_req;
    logic       stop_req;
    logic [2:0] osts;
    logic       mclk_tick;
    logic       cpu_on_main;
    logic       mstop;
    logic       main_ready;
    logic [7:0] ostc;
    logic       stop_rej;
    logic       busy;

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    main_osc_stab_ctl dut (
        .BASECK      (clk),
        .RESET       (rst),
        .OSCSEL      (oscsel),
        .START_REQ   (start_req),
        .STOP_REQ    (stop_req),
        .OSTS        (osts),
        .MCLK_TICK   (mclk_tick),
        .CPU_ON_MAIN (cpu_on_main),
        .MSTOP       (mstop),
        .MAIN_READY  (main_ready),
        .OSTC        (ostc),
        .STOP_REJ    (stop_rej),
        .BUSY        (busy)
    );

    // Advance one edge; inputs set before the call are captured, outputs are read 1ns later
    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic check(input string tag, input logic [7:0] obs, input logic [7:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
        $display("check %-16s observed=%0h expected=%0h", tag, obs, exp);
    endtask

    task automatic ticks(input int n, input int gap);
        for (int k = 0; k < n; k++) begin
            mclk_tick = 1'b1;
            step();
            mclk_tick = 1'b0;
            for (int g = 1; g < gap; g++) step();
        end
    endtask

    task automatic start(input logic [2:0] sel);
        osts      = sel;
        start_req = 1'b1;
        step();
        start_req = 1'b0;
    endtask

    task automatic do_reset();
        rst = 1'b1;
        step();
        rst = 1'b0;
    endtask

    initial begin
        rst = 1'b1; oscsel = 1'b1; start_req = 1'b0; stop_req = 1'b0;
        osts = 3'd0; mclk_tick = 1'b0; cpu_on_main = 1'b0;
        step(); step();
        rst = 1'b0;
        check("rst_mstop", {7'd0, mstop}, 8'h01);
        check("rst_ready", {7'd0, main_ready}, 8'h00);
        check("rst_ostc", ostc, 8'h00);
        check("rst_busy", {7'd0, busy}, 8'h00);
        check("rst_rej", {7'd0, stop_rej}, 8'h00);

        // T1: OSTS=0, tick every cycle
        start(3'd0);
        check("t1_mstop", {7'd0, mstop}, 8'h00);
        check("t1_busy", {7'd0, busy}, 8'h01);
        ticks(255, 1);
        check("t1_ready255", {7'd0, main_ready}, 8'h00);
        check("t1_ostc255", ostc, 8'h00);
        ticks(1, 1);
        check("t1_ready256", {7'd0, main_ready}, 8'h01);
        check("t1_busy256", {7'd0, busy}, 8'h00);
        check("t1_ostc256", ostc, 8'h01);

        // T2: OSTS=3, tick every 4th cycle, OSTS changed mid-wait
        do_reset();
        start(3'd3);
        ticks(10, 4);
        osts = 3'd0;
        ticks(2037, 4);
        check("t2_ready2047", {7'd0, main_ready}, 8'h00);
        check("t2_busy2047", {7'd0, busy}, 8'h01);
        check("t2_ostc2047", ostc, 8'h07);
        ticks(1, 4);
        check("t2_ready2048", {7'd0, main_ready}, 8'h01);
        check("t2_ostc2048", ostc, 8'h0F);

        // T3: stop refused while CPU on main, then accepted
        cpu_on_main = 1'b1;
        stop_req    = 1'b1;
        step();
        stop_req    = 1'b0;
        check("t3_rej", {7'd0, stop_rej}, 8'h01);
        check("t3_mstop_rej", {7'd0, mstop}, 8'h00);
        check("t3_ready_rej", {7'd0, main_ready}, 8'h01);
        check("t3_ostc_rej", ostc, 8'h0F);
        step();
        check("t3_rej_clear", {7'd0, stop_rej}, 8'h00);
        cpu_on_main = 1'b0;
        stop_req    = 1'b1;
        step();
        stop_req    = 1'b0;
        check("t3_mstop_stop", {7'd0, mstop}, 8'h01);
        check("t3_ready_stop", {7'd0, main_ready}, 8'h00);
        check("t3_ostc_stop", ostc, 8'h00);
        check("t3_rej_stop", {7'd0, stop_rej}, 8'h00);

        // T4: stop at tick 100, restart counts from 0
        start(3'd0);
        ticks(100, 1);
        check("t4_busy100", {7'd0, busy}, 8'h01);
        stop_req = 1'b1;
        step();
        stop_req = 1'b0;
        check("t4_mstop_stop", {7'd0, mstop}, 8'h01);
        check("t4_ostc_stop", ostc, 8'h00);
        start(3'd0);
        ticks(156, 1);
        check("t4_ready156", {7'd0, main_ready}, 8'h00);
        ticks(99, 1);
        check("t4_ready255", {7'd0, main_ready}, 8'h00);
        ticks(1, 1);
        check("t4_ready256", {7'd0, main_ready}, 8'h01);

        // T5: OSCSEL drop overrides CPU_ON_MAIN; start ignored in port mode; start+stop in IDLE
        cpu_on_main = 1'b1;
        oscsel      = 1'b0;
        step();
        check("t5_mstop_drop", {7'd0, mstop}, 8'h01);
        check("t5_ready_drop", {7'd0, main_ready}, 8'h00);
        check("t5_rej_drop", {7'd0, stop_rej}, 8'h00);
        cpu_on_main = 1'b0;
        start(3'd0);
        check("t5_mstop_port", {7'd0, mstop}, 8'h01);
        check("t5_busy_port", {7'd0, busy}, 8'h00);
        oscsel    = 1'b1;
        start_req = 1'b1;
        stop_req  = 1'b1;
        step();
        start_req = 1'b0;
        stop_req  = 1'b0;
        check("t5_mstop_both", {7'd0, mstop}, 8'h01);
        check("t5_busy_both", {7'd0, busy}, 8'h00);

        // T6: reset mid-wait at tick 50, then restart from 0
        start(3'd0);
        ticks(50, 1);
        mclk_tick = 1'b1;
        do_reset();
        mclk_tick = 1'b0;
        check("t6_mstop_rst", {7'd0, mstop}, 8'h01);
        check("t6_ready_rst", {7'd0, main_ready}, 8'h00);
        check("t6_busy_rst", {7'd0, busy}, 8'h00);
        check("t6_ostc_rst", ostc, 8'h00);
        start(3'd0);
        ticks(255, 1);
        check("t6_ready255", {7'd0, main_ready}, 8'h00);
        ticks(1, 1);
        check("t6_ready256", {7'd0, main_ready}, 8'h01);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
